// File: rtl/imem_boot_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = loader side, slave = stream source / memory / core side.
interface imem_boot_if #(
  parameter int NUM_WORDS = 256
);
  localparam int ADDR_W = $clog2(NUM_WORDS);

  // A byte moves on a rising edge where in_valid && in_ready are both high;
  // in_data is don't-care otherwise, and in_valid may drop between bytes.
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed little-endian byte image into instruction memory and
// holds the core in reset until done. Define BOOT_CKSUM_EN for a trailing XOR checksum.
module imem_boot_loader #(
  parameter int NUM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  imem_boot_if.master       bus,
  output logic [2:0]        dbg_state
);
  localparam int ADDR_W = $clog2(NUM_WORDS);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
`ifdef BOOT_CKSUM_EN
    S_CKSUM = 3'd3,
`endif
    S_FIN   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [1:0]        bcnt;
  logic [23:0]       word;
  logic [ADDR_W-1:0] idx;
  logic              fire;
`ifdef BOOT_CKSUM_EN
  logic [7:0]        xor_acc;
`endif

  assign fire      = bus.in_valid & bus.in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_LEN0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.core_rst   <= 1'b1;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
      len_lo         <= '0;
      len            <= '0;
      bcnt           <= '0;
      word           <= '0;
      idx            <= '0;
`ifdef BOOT_CKSUM_EN
      xor_acc        <= '0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        S_LEN0: begin
          bus.in_ready <= 1'b1;
          if (fire) begin
            len_lo <= bus.in_data;
`ifdef BOOT_CKSUM_EN
            xor_acc <= bus.in_data;
`endif
            state <= S_LEN1;
          end
        end

        S_LEN1: begin
          if (fire) begin
            len <= {bus.in_data, len_lo};
`ifdef BOOT_CKSUM_EN
            xor_acc <= xor_acc ^ bus.in_data;
`endif
            if ({1'b0, bus.in_data, len_lo} > 17'(NUM_WORDS)) begin
              state        <= S_ERR;
              bus.in_ready <= 1'b0;
            end else if ({bus.in_data, len_lo} == 16'd0) begin
`ifdef BOOT_CKSUM_EN
              state        <= S_CKSUM;
`else
              state        <= S_FIN;
              bus.in_ready <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (fire) begin
`ifdef BOOT_CKSUM_EN
            xor_acc <= xor_acc ^ bus.in_data;
`endif
            bcnt <= bcnt + 2'd1;
            // Shift right so the first byte of a word ends up in bits [7:0].
            word <= {bus.in_data, word[23:8]};
            if (bcnt == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= {bus.in_data, word};
              bus.imem_addr  <= idx;
              idx            <= idx + ADDR_W'(1);
              if (17'(idx) + 17'd1 == {1'b0, len}) begin
`ifdef BOOT_CKSUM_EN
                state        <= S_CKSUM;
`else
                state        <= S_FIN;
                bus.in_ready <= 1'b0;
`endif
              end
            end
          end
        end

`ifdef BOOT_CKSUM_EN
        S_CKSUM: begin
          if (fire) begin
            bus.in_ready <= 1'b0;
            state        <= (bus.in_data == xor_acc) ? S_FIN : S_ERR;
          end
        end
`endif

        S_FIN: begin
          bus.in_ready <= 1'b0;
          bus.done     <= 1'b1;
          bus.core_rst <= 1'b0;
          state        <= S_DONE;
        end

        S_DONE: begin
          bus.in_ready <= 1'b0;
        end

        S_ERR: begin
          bus.in_ready <= 1'b0;
          bus.error    <= 1'b1;
          bus.core_rst <= 1'b1;
        end

        default: begin
          bus.in_ready <= 1'b0;
          state        <= S_ERR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: scenario tasks, a negedge monitor,
// and a byte-stream reference model producing the expected write queue.
module tb_imem_boot_loader;
  localparam int NUM_WORDS = 256;
  localparam int ADDR_W    = $clog2(NUM_WORDS);
  localparam int W         = ADDR_W + 32;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  imem_boot_if #(.NUM_WORDS(NUM_WORDS)) bus ();

  imem_boot_loader #(.NUM_WORDS(NUM_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  // ---------------- monitor ----------------
  int           acc_cyc[$];
  int           we_cyc[$];
  logic [W-1:0] we_val[$];
  int           done_cyc = -1;
  int           err_cyc  = -1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
      if (bus.imem_we) begin
        we_cyc.push_back(cyc);
        we_val.push_back({bus.imem_addr, bus.imem_wdata});
      end
      if (bus.done && done_cyc < 0) done_cyc = cyc;
      if (bus.error && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic clear_mon();
    acc_cyc.delete();
    we_cyc.delete();
    we_val.delete();
    done_cyc = -1;
    err_cyc  = -1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   stim_q[$];
  logic [W-1:0] exp_q[$];
  int           exp_cons;
  bit           exp_done;
  bit           exp_err;
  bit           exp_err_timed;

  task automatic model_run();
    int          len;
    int          n;
    logic [31:0] d;
    logic [7:0]  x;
    exp_q.delete();
    exp_done      = 1'b0;
    exp_err       = 1'b0;
    exp_err_timed = 1'b0;
    len = int'({stim_q[1], stim_q[0]});
    if (len > NUM_WORDS) begin
      exp_err  = 1'b1;
      exp_cons = 2;
      return;
    end
    for (int w = 0; w < len; w++) begin
      d = {stim_q[2+4*w+3], stim_q[2+4*w+2], stim_q[2+4*w+1], stim_q[2+4*w]};
      exp_q.push_back({ADDR_W'(w), d});
    end
    n = 2 + 4 * len;
    x = 8'h00;
    for (int i = 0; i < n; i++) x ^= stim_q[i];
`ifdef BOOT_CKSUM_EN
    exp_cons = n + 1;
    if (stim_q[n] == x) exp_done = 1'b1;
    else begin
      exp_err       = 1'b1;
      exp_err_timed = 1'b1;
    end
`else
    exp_cons = n;
    exp_done = 1'b1;
`endif
  endtask

  task automatic append_cksum();
`ifdef BOOT_CKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (stim_q[i]) x ^= stim_q[i];
    stim_q.push_back(x);
`endif
  endtask

  task automatic build_image(input int len);
    stim_q.delete();
    stim_q.push_back(len[7:0]);
    stim_q.push_back(len[15:8]);
    for (int i = 0; i < 4 * len; i++) stim_q.push_back(8'($urandom_range(255, 0)));
    append_cksum();
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive_stream(input int gap_max, output bit ok);
    int g;
    int t;
    ok = 1'b1;
    foreach (stim_q[i]) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom_range(255, 0));
        repeat (g) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim_q[i];
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!bus.in_ready) begin
        ok = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic run_stream(input string name, input int gap_max);
    bit           ok;
    int           nexp;
    int           bubbles;
    logic [W-1:0] e;
    model_run();
    nexp = exp_q.size();
    clear_mon();
    drive_stream(gap_max, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s handshake: in_ready timeout after %0d accepted bytes, required %0d", name, acc_cyc.size(), exp_cons);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);

    tests++;
    if (acc_cyc.size() != exp_cons) begin
      fails++;
      $display("FAIL %s accepted: got %0d bytes, required %0d", name, acc_cyc.size(), exp_cons);
    end
    tests++;
    if (we_val.size() != nexp) begin
      fails++;
      $display("FAIL %s write_count: got %0d, required %0d", name, we_val.size(), nexp);
    end
    for (int w = 0; w < we_val.size() && exp_q.size() > 0; w++) begin
      e = exp_q.pop_front();
      tests++;
      if (we_val[w] !== e) begin
        fails++;
        $display("FAIL %s write%0d: got addr/data %h, required %h", name, w, we_val[w], e);
      end
      if (2 + 4 * w + 3 < acc_cyc.size()) begin
        tests++;
        if (we_cyc[w] != acc_cyc[2+4*w+3] + 1) begin
          fails++;
          $display("FAIL %s write%0d_latency: got cycle %0d, required %0d", name, w, we_cyc[w], acc_cyc[2+4*w+3] + 1);
        end
      end
    end

    tests++;
    if (bus.done !== exp_done) begin
      fails++;
      $display("FAIL %s done: got %b, required %b", name, bus.done, exp_done);
    end
    tests++;
    if (bus.error !== exp_err) begin
      fails++;
      $display("FAIL %s error: got %b, required %b", name, bus.error, exp_err);
    end
    tests++;
    if (bus.core_rst !== !exp_done) begin
      fails++;
      $display("FAIL %s core_rst: got %b, required %b", name, bus.core_rst, !exp_done);
    end
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s in_ready_after: got %b, required 0", name, bus.in_ready);
    end
    if (exp_done && acc_cyc.size() == exp_cons) begin
      tests++;
      if (done_cyc != acc_cyc[exp_cons-1] + 2) begin
        fails++;
        $display("FAIL %s done_latency: got cycle %0d, required %0d", name, done_cyc, acc_cyc[exp_cons-1] + 2);
      end
    end
    if (exp_err_timed && acc_cyc.size() == exp_cons) begin
      tests++;
      if (err_cyc != acc_cyc[exp_cons-1] + 2) begin
        fails++;
        $display("FAIL %s error_latency: got cycle %0d, required %0d", name, err_cyc, acc_cyc[exp_cons-1] + 2);
      end
    end
    if (gap_max == 0) begin
      bubbles = 0;
      for (int i = 1; i < acc_cyc.size(); i++)
        if (acc_cyc[i] != acc_cyc[i-1] + 1) bubbles++;
      tests++;
      if (bubbles != 0) begin
        fails++;
        $display("FAIL %s full_rate: got %0d bubbles, required 0", name, bubbles);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic check_reset_values(input string name);
    tests++;
    if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== '0 ||
        bus.imem_wdata !== 32'h0 || bus.core_rst !== 1'b1 || bus.done !== 1'b0 ||
        bus.error !== 1'b0) begin
      fails++;
      $display("FAIL %s: got rdy=%b we=%b addr=%h wdata=%h core_rst=%b done=%b err=%b, required 0 0 0 0 1 0 0",
               name, bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
               bus.core_rst, bus.done, bus.error);
    end
  endtask

  task automatic test_reset();
    check_reset_values("reset_values");
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got in_ready %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_two_word();
    do_reset();
    stim_q = '{8'h02, 8'h00, 8'hB3, 8'h01, 8'h22, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    append_cksum();
    run_stream("two_word", 0);
    tests++;
    if (we_val.size() != 2 || we_val[0] !== {ADDR_W'(0), 32'h002201B3} ||
        we_val[1] !== {ADDR_W'(1), 32'h00000013}) begin
      fails++;
      $display("FAIL two_word_vector: got %0d writes, required %h then %h", we_val.size(),
               {ADDR_W'(0), 32'h002201B3}, {ADDR_W'(1), 32'h00000013});
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    stim_q = '{8'h00, 8'h00};
    append_cksum();
    run_stream("zero_len", 0);
  endtask

  task automatic test_overlength();
    do_reset();
    stim_q = '{8'h01, 8'h01};
    run_stream("overlength_257", 0);
    do_reset();
    stim_q.delete();
    stim_q.push_back(8'($urandom_range(255, 0)));
    stim_q.push_back(8'($urandom_range(255, 2)));
    run_stream("overlength_rand", 2);
  endtask

  task automatic test_gapped();
    do_reset();
    stim_q = '{8'h02, 8'h00, 8'hB3, 8'h01, 8'h22, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    append_cksum();
    run_stream("gapped", 3);
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    do_reset();
    stim_q = '{8'h01, 8'h00, 8'hB3, 8'h01};
    drive_stream(0, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL mid_word_prefix: in_ready timeout, got ok=%b, required 1", ok);
    end
    do_reset();
    check_reset_values("mid_word_reset_values");
    stim_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    append_cksum();
    run_stream("after_mid_reset", 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      do_reset();
      build_image(int'($urandom_range(9, 1)));
      run_stream($sformatf("random%0d", k), int'($urandom_range(3, 0)));
    end
  endtask

  task automatic test_max_len();
    do_reset();
    build_image(NUM_WORDS);
    run_stream("max_len", 0);
  endtask

`ifdef BOOT_CKSUM_EN
  task automatic test_cksum();
    do_reset();
    stim_q = '{8'h01, 8'h00, 8'hB3, 8'h01, 8'h22, 8'h00, 8'h91};
    run_stream("cksum_good", 0);
    do_reset();
    stim_q = '{8'h01, 8'h00, 8'hB3, 8'h01, 8'h22, 8'h00, 8'h90};
    run_stream("cksum_bad", 0);
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_two_word();
    test_zero_len();
    test_overlength();
    test_gapped();
    test_reset_mid_word();
    test_random();
    test_max_len();
`ifdef BOOT_CKSUM_EN
    test_cksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
